// File: rtl/quad_axis_scheduler.sv
// Quadrature counter bank sequencer: zeroing pulses, coherent position snapshots,
// per-axis velocity deltas and a req/ack read port onto the published results.
module quad_axis_scheduler #(
    parameter int NUM_AXES = 4,
    parameter int CNT_W    = 32,
    parameter int PERIOD_W = 24,
    parameter int AW       = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_AXES*CNT_W-1:0] count_flat,
    output logic [NUM_AXES-1:0]       counter_clr,
    input  logic [NUM_AXES-1:0]       zero_req,
    input  logic                      snap_req,
    input  logic [PERIOD_W-1:0]       period,
    input  logic                      period_load,
    input  logic                      ovr_clr,
    input  logic                      rd_req,
    input  logic [AW-1:0]             rd_addr,
    output logic                      rd_ack,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      snap_valid,
    output logic [15:0]               snap_seq,
    output logic                      busy,
    output logic                      overrun
);
    localparam int KW = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_ZWAIT, S_CAPTURE, S_DELTA, S_PUBLISH
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_AXES-1:0] zero_pend_q, zero_pend_d;
    logic                snap_pend_q, snap_pend_d;
    logic                overrun_q, overrun_d;
    logic [PERIOD_W-1:0] period_q, timer_q, timer_d;
    logic [KW-1:0]       k_q, k_d;
    logic                tmr_exp, snap_trig;

    logic [CNT_W-1:0] pos_new_q    [NUM_AXES];
    logic [CNT_W-1:0] vel_new_q    [NUM_AXES];
    logic [CNT_W-1:0] prev_q       [NUM_AXES];
    logic [CNT_W-1:0] shadow_pos_q [NUM_AXES];
    logic [CNT_W-1:0] shadow_vel_q [NUM_AXES];

    logic             snap_valid_q;
    logic [15:0]      snap_seq_q;
    logic             rd_ack_q;
    logic [CNT_W-1:0] rd_data_q, rd_mux;

    always_comb begin
        tmr_exp = (period_q != '0) && (timer_q == PERIOD_W'(1)) && !period_load;
        if (period_load)
            timer_d = period;
        else if (period_q == '0)
            timer_d = '0;
        else if (timer_q <= PERIOD_W'(1))
            timer_d = period_q;
        else
            timer_d = timer_q - PERIOD_W'(1);
    end

    assign snap_trig = snap_req | tmr_exp;

    // IDLE acts on same-cycle requests so snap_req in cycle t publishes at t+N+3.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        zero_pend_d = zero_pend_q | zero_req;
        snap_pend_d = snap_pend_q | snap_trig;
        overrun_d   = (overrun_q & ~ovr_clr) | (snap_trig & snap_pend_q);
        case (state_q)
            S_IDLE: begin
                if ((zero_pend_q | zero_req) != '0)
                    state_d = S_ZERO;
                else if (snap_pend_q | snap_trig)
                    state_d = S_CAPTURE;
            end
            S_ZERO: begin
                zero_pend_d = zero_req;
                state_d     = S_ZWAIT;
            end
            S_ZWAIT:  state_d = S_IDLE;
            S_CAPTURE: begin
                snap_pend_d = 1'b0;
                k_d         = '0;
                state_d     = S_DELTA;
            end
            S_DELTA: begin
                k_d = k_q + KW'(1);
                if (k_q == KW'(NUM_AXES - 1))
                    state_d = S_PUBLISH;
            end
            S_PUBLISH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            zero_pend_q <= '0;
            snap_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            period_q    <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            zero_pend_q <= zero_pend_d;
            snap_pend_q <= snap_pend_d;
            overrun_q   <= overrun_d;
            timer_q     <= timer_d;
            if (period_load)
                period_q <= period;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_AXES; i++) begin
                pos_new_q[i]    <= '0;
                vel_new_q[i]    <= '0;
                prev_q[i]       <= '0;
                shadow_pos_q[i] <= '0;
                shadow_vel_q[i] <= '0;
            end
            snap_valid_q <= 1'b0;
            snap_seq_q   <= '0;
        end else begin
            snap_valid_q <= (state_q == S_PUBLISH);
            case (state_q)
                S_ZERO: begin
                    for (int unsigned i = 0; i < NUM_AXES; i++)
                        if (zero_pend_q[i])
                            prev_q[i] <= '0;
                end
                S_CAPTURE: begin
                    for (int unsigned i = 0; i < NUM_AXES; i++)
                        pos_new_q[i] <= count_flat[i*CNT_W +: CNT_W];
                end
                S_DELTA: begin
                    vel_new_q[k_q] <= pos_new_q[k_q] - prev_q[k_q];
                    prev_q[k_q]    <= pos_new_q[k_q];
                end
                S_PUBLISH: begin
                    for (int unsigned i = 0; i < NUM_AXES; i++) begin
                        shadow_pos_q[i] <= pos_new_q[i];
                        shadow_vel_q[i] <= vel_new_q[i];
                    end
                    snap_seq_q <= snap_seq_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            if (rd_addr == AW'(i))
                rd_mux = shadow_pos_q[i];
            if (rd_addr == AW'(i + NUM_AXES))
                rd_mux = shadow_vel_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_req & ~rd_ack_q;
            if (rd_req && !rd_ack_q)
                rd_data_q <= rd_mux;
        end
    end

    assign counter_clr = (state_q == S_ZERO) ? zero_pend_q : '0;
    assign busy        = (state_q != S_IDLE);
    assign overrun     = overrun_q;
    assign snap_valid  = snap_valid_q;
    assign snap_seq    = snap_seq_q;
    assign rd_ack      = rd_ack_q;
    assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_quad_axis_scheduler.sv
// Scoreboard bench for quad_axis_scheduler: stimulus pushes expected snapshots and
// read data, a negedge monitor pops and compares whenever snap_valid or rd_ack fires.
module tb_quad_axis_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int PW = 24;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    cnt [N];
    logic [N*W-1:0]  count_flat;
    logic [N-1:0]    counter_clr;
    logic [N-1:0]    zero_req;
    logic            snap_req;
    logic [PW-1:0]   period;
    logic            period_load;
    logic            ovr_clr;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_ack;
    logic [W-1:0]    rd_data;
    logic            snap_valid;
    logic [15:0]     snap_seq;
    logic            busy;
    logic            overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int           exp_snap_seq [$];
    int           exp_snap_cyc [$];
    logic [W-1:0] exp_rd       [$];

    assign count_flat = {cnt[3], cnt[2], cnt[1], cnt[0]};

    quad_axis_scheduler #(
        .NUM_AXES (N),
        .CNT_W    (W),
        .PERIOD_W (PW),
        .AW       (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_flat  (count_flat),
        .counter_clr (counter_clr),
        .zero_req    (zero_req),
        .snap_req    (snap_req),
        .period      (period),
        .period_load (period_load),
        .ovr_clr     (ovr_clr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .snap_valid  (snap_valid),
        .snap_seq    (snap_seq),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (snap_valid === 1'b1) begin
            if (exp_snap_seq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_snap_valid: got pulse at cycle %0d seq %0d expected none", cyc, snap_seq);
            end else begin
                int s;
                int c;
                s = exp_snap_seq.pop_front();
                c = exp_snap_cyc.pop_front();
                chk("snap_seq", 64'(snap_seq), 64'(s));
                chk("snap_cycle", 64'(cyc), 64'(c));
            end
        end
        if (rd_ack === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rd_ack: got ack at cycle %0d data %0h expected none", cyc, rd_data);
            end else begin
                logic [W-1:0] e;
                e = exp_rd.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap(input int seq, input int lat);
        exp_snap_seq.push_back(seq);
        exp_snap_cyc.push_back(cyc + lat);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
    endtask

    task automatic rd(input int a, input logic [W-1:0] e);
        exp_rd.push_back(e);
        rd_addr = AW'(a);
        rd_req  = 1'b1;
        tick(1);
        rd_req  = 1'b0;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] tbl [8];
        int t;
        int l;

        reset = 1'b0; zero_req = '0; snap_req = 1'b0; period = '0;
        period_load = 1'b0; ovr_clr = 1'b0; rd_req = 1'b0; rd_addr = '0;
        for (int i = 0; i < N; i++) cnt[i] = '0;

        // Reset and idle
        tick(3);
        reset = 1'b1;
        chk("rst_counter_clr", 64'(counter_clr), 64'h0);
        chk("rst_rd_ack",      64'(rd_ack),      64'h0);
        chk("rst_rd_data",     64'(rd_data),     64'h0);
        chk("rst_snap_valid",  64'(snap_valid),  64'h0);
        chk("rst_snap_seq",    64'(snap_seq),    64'h0);
        chk("rst_busy",        64'(busy),        64'h0);
        chk("rst_overrun",     64'(overrun),     64'h0);
        tick(100);
        chk("idle_busy",     64'(busy),     64'h0);
        chk("idle_snap_seq", 64'(snap_seq), 64'h0);

        // Single snapshot: first one uses prev=0 so vel=pos
        cnt[0] = 32'd40; cnt[1] = 32'hFFFF_FFFB; cnt[2] = 32'd0; cnt[3] = 32'd7;
        snap(1, 7);
        tick(8);
        tbl = '{32'd40, 32'hFFFF_FFFB, 32'd0, 32'd7, 32'd40, 32'hFFFF_FFFB, 32'd0, 32'd7};
        for (int a = 0; a < 8; a++) rd(a, tbl[a]);

        // Preload axis1 prev = 0x80000001 (vel = 0x80000001 - (-5))
        cnt[1] = 32'h8000_0001;
        snap(2, 7);
        tick(8);
        rd(1, 32'h8000_0001);
        rd(5, 32'h8000_0006);

        // Velocity with negative delta and wrap
        cnt[0] = 32'd15; cnt[1] = 32'h7FFF_FFFF;
        snap(3, 7);
        tick(8);
        rd(0, 32'd15);
        rd(1, 32'h7FFF_FFFF);
        rd(4, 32'hFFFF_FFE7);
        rd(5, 32'hFFFF_FFFE);
        rd(6, 32'd0);
        rd(7, 32'd0);

        // Zero has priority over a same-cycle snapshot
        exp_snap_seq.push_back(4);
        exp_snap_cyc.push_back(cyc + 10);
        zero_req = 4'b0010;
        snap_req = 1'b1;
        tick(1);
        zero_req = '0;
        snap_req = 1'b0;
        chk("zero_counter_clr", 64'(counter_clr), 64'h2);
        chk("zero_busy",        64'(busy),        64'h1);
        tick(1);
        chk("zwait_counter_clr", 64'(counter_clr), 64'h0);
        cnt[1] = '0;
        tick(10);
        rd(0, 32'd15);
        rd(1, 32'd0);
        rd(4, 32'd0);
        rd(5, 32'd0);

        // Periodic snapshots every 20 cycles, then disable
        l = cyc;
        exp_snap_seq.push_back(5); exp_snap_cyc.push_back(l + 27);
        exp_snap_seq.push_back(6); exp_snap_cyc.push_back(l + 47);
        exp_snap_seq.push_back(7); exp_snap_cyc.push_back(l + 67);
        period = PW'(20);
        period_load = 1'b1;
        tick(1);
        period_load = 1'b0;
        tick(69);
        period = '0;
        period_load = 1'b1;
        tick(1);
        period_load = 1'b0;
        tick(40);
        chk("periodic_off_seq", 64'(snap_seq), 64'd7);

        // Overrun: two triggers while a snapshot is already pending
        t = cyc;
        exp_snap_seq.push_back(8); exp_snap_cyc.push_back(t + 7);
        exp_snap_seq.push_back(9); exp_snap_cyc.push_back(t + 14);
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(1);
        snap_req = 1'b1;
        tick(3);
        snap_req = 1'b0;
        chk("overrun_set", 64'(overrun), 64'h1);
        tick(15);
        chk("overrun_sticky", 64'(overrun), 64'h1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("overrun_clr", 64'(overrun), 64'h0);
        rd(4, 32'd0);

        // Reset in the middle of DELTA aborts the sequence
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(2);
        chk("mid_busy", 64'(busy), 64'h1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        chk("abort_busy",     64'(busy),        64'h0);
        chk("abort_snap_seq", 64'(snap_seq),    64'h0);
        chk("abort_overrun",  64'(overrun),     64'h0);
        chk("abort_clr",      64'(counter_clr), 64'h0);
        tick(12);
        rd(0, 32'd0);
        rd(4, 32'd0);

        tick(3);
        chk("snap_queue_left", 64'(exp_snap_seq.size()), 64'h0);
        chk("rd_queue_left",   64'(exp_rd.size()),       64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
